// File: rtl/capture_ctrl_pkg.sv
// Shared definitions for capture_ctrl: FSM state encoding, register map, CSR/STATUS bit positions.
// Pure declarations; no logic, no latency, no flow control.
package capture_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_WAIT_CLR = 3'd2,
        S_WAIT_RDY = 3'd3,
        S_DONE     = 3'd4,
        S_HOLD     = 3'd5
    } cap_state_t;

    localparam logic [1:0] ADR_CSR     = 2'd0;
    localparam logic [1:0] ADR_STATUS  = 2'd1;
    localparam logic [1:0] ADR_COUNT   = 2'd2;
    localparam logic [1:0] ADR_TIMEOUT = 2'd3;

    localparam int CSR_START     = 0;
    localparam int CSR_AUTO      = 1;
    localparam int CSR_IRQ_EN    = 2;
    localparam int CSR_ABORT     = 3;
    localparam int CSR_STATE_LSB = 4;
    localparam int CSR_BUSY      = 8;

    localparam int ST_DONE  = 0;
    localparam int ST_TMO   = 1;
    localparam int ST_READY = 2;

    localparam int COUNT_W = 16;

endpackage

// File: rtl/capture_ctrl_if.sv
// Wishbone classic slave bus for the capture_ctrl register window.
// Latency and backpressure are defined by the slave: one ack cycle per access.
interface capture_ctrl_if;
    logic [1:0]  wb_adr;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack;

    modport master (
        output wb_adr, wb_cyc, wb_stb, wb_we, wb_sel, wb_dat_i,
        input  wb_dat_o, wb_ack
    );

    modport slave (
        input  wb_adr, wb_cyc, wb_stb, wb_we, wb_sel, wb_dat_i,
        output wb_dat_o, wb_ack
    );
endinterface

// File: rtl/capture_ctrl_sync.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
// Latency: 2 clk cycles; no backpressure.
module capctrl_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) ff <= 2'b00;
        else     ff <= {ff[0], d};
    end

    assign q = ff[1];
endmodule

// File: rtl/capture_ctrl.sv
// Capture RAM sequencer: arms cntrl_run, tracks cntrl_ready, counts captures, raises irq.
// Bus access acks one cycle after acceptance; no wait states. Optional timeout: CAPCTRL_TIMEOUT_EN.
module capture_ctrl
    import capture_ctrl_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int TMO_W   = 24
) (
    input  logic           wb_clk,
    input  logic           wb_rst,
    capture_ctrl_if.slave  wb,
    input  logic           cntrl_ready,
    output logic           cntrl_run,
    output logic           busy,
    output logic           irq
);
    localparam int RC_W = $clog2(RUN_LEN + 1);
    localparam logic [RC_W-1:0] RUN_LAST = RC_W'(RUN_LEN - 1);

    cap_state_t         state;
    logic [RC_W-1:0]    run_cnt;
    logic               ready_s;
    logic               auto_en;
    logic               irq_en;
    logic               done_flag;
    logic               tmo_flag;
    logic [COUNT_W-1:0] count;
    logic               tmo_hit;
    logic [31:0]        timeout_rd;
    logic [31:0]        rd_dat;

    logic acc, wr, wr_csr, wr_status, wr_count, start_req, abort_req;

    assign acc       = wb.wb_cyc & wb.wb_stb & ~wb.wb_ack;
    assign wr        = acc & wb.wb_we;
    assign wr_csr    = wr && (wb.wb_adr == ADR_CSR);
    assign wr_status = wr && (wb.wb_adr == ADR_STATUS);
    assign wr_count  = wr && (wb.wb_adr == ADR_COUNT);
    assign start_req = wr_csr & wb.wb_sel[0] & wb.wb_dat_i[CSR_START];
    assign abort_req = wr_csr & wb.wb_sel[0] & wb.wb_dat_i[CSR_ABORT];

    logic unused_bus;
    assign unused_bus = ^{wb.wb_dat_i, wb.wb_sel};

    capctrl_sync u_sync (
        .clk (wb_clk),
        .rst (wb_rst),
        .d   (cntrl_ready),
        .q   (ready_s)
    );

`ifdef CAPCTRL_TIMEOUT_EN
    logic [TMO_W-1:0] timeout_r;
    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = ((state == S_WAIT_CLR) || (state == S_WAIT_RDY)) &&
                     (timeout_r != '0) && (tmo_cnt == timeout_r);
    assign timeout_rd = 32'(timeout_r);

    // Counter is held at zero while arming, so it starts fresh on entry to WAIT_CLR.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            tmo_cnt   <= '0;
            timeout_r <= '0;
        end else begin
            if (state == S_ARM)
                tmo_cnt <= '0;
            else if ((state == S_WAIT_CLR) || (state == S_WAIT_RDY))
                tmo_cnt <= tmo_cnt + 1'b1;
            if (wr && (wb.wb_adr == ADR_TIMEOUT)) begin
                for (int i = 0; i < TMO_W; i++)
                    if (wb.wb_sel[i/8]) timeout_r[i] <= wb.wb_dat_i[i];
            end
        end
    end
`else
    assign tmo_hit    = 1'b0;
    assign timeout_rd = 32'd0;
`endif

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state     <= S_IDLE;
            cntrl_run <= 1'b0;
            run_cnt   <= '0;
        end else if (abort_req) begin
            state     <= S_IDLE;
            cntrl_run <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start_req) begin
                    state     <= S_ARM;
                    cntrl_run <= 1'b1;
                    run_cnt   <= '0;
                end
                S_ARM: if (run_cnt == RUN_LAST) begin
                    state     <= S_WAIT_CLR;
                    cntrl_run <= 1'b0;
                end else begin
                    run_cnt <= run_cnt + 1'b1;
                end
                S_WAIT_CLR: if (tmo_hit)       state <= S_IDLE;
                            else if (!ready_s) state <= S_WAIT_RDY;
                S_WAIT_RDY: if (tmo_hit)       state <= S_IDLE;
                            else if (ready_s)  state <= S_DONE;
                S_DONE:     state <= auto_en ? S_HOLD : S_IDLE;
                // Re-arm only once software has consumed the previous buffer.
                S_HOLD: if (!auto_en) begin
                    state <= S_IDLE;
                end else if (!done_flag) begin
                    state     <= S_ARM;
                    cntrl_run <= 1'b1;
                    run_cnt   <= '0;
                end
                default: begin
                    state     <= S_IDLE;
                    cntrl_run <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            auto_en   <= 1'b0;
            irq_en    <= 1'b0;
            done_flag <= 1'b0;
            tmo_flag  <= 1'b0;
            count     <= '0;
        end else begin
            if (wr_csr && wb.wb_sel[0]) begin
                auto_en <= wb.wb_dat_i[CSR_AUTO];
                irq_en  <= wb.wb_dat_i[CSR_IRQ_EN];
            end
            if (state == S_DONE)
                done_flag <= 1'b1;
            else if (wr_status && wb.wb_sel[0] && wb.wb_dat_i[ST_DONE])
                done_flag <= 1'b0;
            if (tmo_hit && !abort_req)
                tmo_flag <= 1'b1;
            else if (wr_status && wb.wb_sel[0] && wb.wb_dat_i[ST_TMO])
                tmo_flag <= 1'b0;
            if (wr_count)
                count <= '0;
            else if ((state == S_DONE) && (count != {COUNT_W{1'b1}}))
                count <= count + 1'b1;
        end
    end

    always_comb begin
        rd_dat = 32'd0;
        case (wb.wb_adr)
            ADR_CSR: begin
                rd_dat[CSR_AUTO]                    = auto_en;
                rd_dat[CSR_IRQ_EN]                  = irq_en;
                rd_dat[CSR_STATE_LSB +: 3]          = state;
                rd_dat[CSR_BUSY]                    = busy;
            end
            ADR_STATUS: begin
                rd_dat[ST_DONE]  = done_flag;
                rd_dat[ST_TMO]   = tmo_flag;
                rd_dat[ST_READY] = ready_s;
            end
            ADR_COUNT:   rd_dat = 32'(count);
            default:     rd_dat = timeout_rd;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wb.wb_ack   <= 1'b0;
            wb.wb_dat_o <= 32'd0;
        end else begin
            wb.wb_ack <= acc;
            if (acc) wb.wb_dat_o <= rd_dat;
        end
    end

    assign busy = (state != S_IDLE);
    assign irq  = irq_en & (done_flag | tmo_flag);

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomized bench for capture_ctrl against a transaction-level register/capture model.
module tb_capture_ctrl;
    import capture_ctrl_pkg::*;

    localparam int RUN_LEN = 4;
    localparam int TMO_W   = 24;

    logic wb_clk = 1'b0;
    logic wb_rst = 1'b1;
    logic man_ready = 1'b0;
    logic mdl_ready = 1'b0;
    logic ram_en = 1'b0;
    logic cntrl_ready;
    logic cntrl_run, busy, irq;

    assign cntrl_ready = ram_en ? mdl_ready : man_ready;
    always #5 wb_clk = ~wb_clk;

    capture_ctrl_if wb_bus ();

    capture_ctrl #(.RUN_LEN(RUN_LEN), .TMO_W(TMO_W)) dut (
        .wb_clk      (wb_clk),
        .wb_rst      (wb_rst),
        .wb          (wb_bus),
        .cntrl_ready (cntrl_ready),
        .cntrl_run   (cntrl_run),
        .busy        (busy),
        .irq         (irq)
    );

    int checks = 0;
    int failures = 0;

    // Capture RAM model and cntrl_run pulse monitor.
    int cyc_n = 0, fall_at = -1, rise_at = -1;
    int run_len = 0, last_len = 0, pulses = 0;
    bit run_q = 1'b0;

    always @(negedge wb_clk) begin
        cyc_n++;
        if (cntrl_run) run_len++;
        if (!cntrl_run && run_q) begin
            pulses++;
            last_len = run_len;
            run_len  = 0;
        end
        if (cntrl_run && !run_q) begin
            fall_at = cyc_n + int'($urandom_range(1, 3));
            rise_at = fall_at + int'($urandom_range(2, 30));
        end
        if (cyc_n == fall_at) mdl_ready = 1'b0;
        if (cyc_n == rise_at) mdl_ready = 1'b1;
        run_q = cntrl_run;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge wb_clk);
        #1;
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        @(posedge wb_clk); #1;
        wb_bus.wb_cyc = 1'b1; wb_bus.wb_stb = 1'b1; wb_bus.wb_we = 1'b1;
        wb_bus.wb_adr = a; wb_bus.wb_dat_i = d; wb_bus.wb_sel = s;
        @(posedge wb_clk); #1;
        wb_bus.wb_cyc = 1'b0; wb_bus.wb_stb = 1'b0; wb_bus.wb_we = 1'b0;
        check("wr_ack", 32'(wb_bus.wb_ack), 32'd1);
    endtask

    task automatic wb_rd(input logic [1:0] a, output logic [31:0] d);
        @(posedge wb_clk); #1;
        wb_bus.wb_cyc = 1'b1; wb_bus.wb_stb = 1'b1; wb_bus.wb_we = 1'b0;
        wb_bus.wb_adr = a; wb_bus.wb_sel = 4'hF;
        @(posedge wb_clk); #1;
        wb_bus.wb_cyc = 1'b0; wb_bus.wb_stb = 1'b0;
        d = wb_bus.wb_dat_o;
    endtask

    task automatic wait_idle(input int max, output int n);
        n = 0;
        while (busy && n < max) begin
            @(posedge wb_clk); #1;
            n++;
        end
        check("idle_bound", 32'(busy), 32'd0);
    endtask

    task automatic wait_hold(input string tag);
        logic [31:0] d;
        int k = 0;
        do begin
            wb_rd(ADR_CSR, d);
            k++;
        end while (d[6:4] != 3'd5 && k < 100);
        check(tag, d, 32'h152);
    endtask

    logic [31:0] rd, wd;
    logic [3:0]  ws;
    int n, p0, exp_count;
    bit exp_done, exp_irq_en;
    logic [TMO_W-1:0] exp_lim;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        wb_bus.wb_cyc = 1'b0; wb_bus.wb_stb = 1'b0; wb_bus.wb_we = 1'b0;
        wb_bus.wb_adr = 2'd0; wb_bus.wb_sel = 4'h0; wb_bus.wb_dat_i = 32'd0;
        exp_count = 0; exp_done = 0; exp_irq_en = 0; exp_lim = '0;
        repeat (3) @(posedge wb_clk);
        #1 wb_rst = 1'b0;

        // Reset state
        check("rst_run", 32'(cntrl_run), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ack", 32'(wb_bus.wb_ack), 0);
        check("rst_dato", wb_bus.wb_dat_o, 0);
        for (int a = 0; a < 4; a++) begin
            wb_rd(2'(a), rd);
            check("rst_reg", rd, 0);
        end

        // Single capture with IRQ
        man_ready = 1'b1;
        cycles(4);
        p0 = pulses;
        wb_wr(ADR_CSR, 32'h5, 4'hF);
        check("run_next", 32'(cntrl_run), 1);
        cycles(1);
        check("ack_1cyc", 32'(wb_bus.wb_ack), 0);
        cycles(6);
        man_ready = 1'b0;
        cycles(20);
        man_ready = 1'b1;
        wait_idle(10, n);
        check("rdy_to_idle", 32'(n >= 3 && n <= 4), 1);
        check("pulse_cnt1", 32'(pulses), 32'(p0 + 1));
        check("pulse_len1", 32'(last_len), 32'(RUN_LEN));
        wb_rd(ADR_STATUS, rd); check("status_done", rd, 32'h5);
        wb_rd(ADR_COUNT, rd);  check("count1", rd, 32'd1);
        check("irq_set", 32'(irq), 1);
        wb_wr(ADR_STATUS, 32'h1, 4'hF);
        check("irq_clr", 32'(irq), 0);
        wb_rd(ADR_STATUS, rd); check("status_w1c", rd, 32'h4);

        // AUTO mode with HOLD
        wb_wr(ADR_COUNT, $urandom, 4'hF);
        wb_rd(ADR_COUNT, rd); check("count_clr", rd, 0);
        ram_en = 1'b1;
        p0 = pulses;
        wb_wr(ADR_CSR, 32'h3, 4'hF);
        wait_hold("hold1");
        cycles(30);
        wb_rd(ADR_CSR, rd); check("hold_stay", rd, 32'h152);
        check("hold_pulses", 32'(pulses), 32'(p0 + 1));
        wb_rd(ADR_COUNT, rd); check("auto_count1", rd, 32'd1);
        wb_wr(ADR_STATUS, 32'h1, 4'hF);
        wait_hold("hold2");
        check("rearm_pulses", 32'(pulses), 32'(p0 + 2));
        wb_rd(ADR_COUNT, rd); check("auto_count2", rd, 32'd2);
        wb_wr(ADR_CSR, 32'h0, 4'hF);
        cycles(2);
        wb_rd(ADR_CSR, rd); check("auto_off", rd, 32'h0);
        wb_wr(ADR_STATUS, 32'h1, 4'hF);

        // ABORT during ARM
        ram_en = 1'b0;
        man_ready = 1'b1;
        cycles(4);
        p0 = pulses;
        wb_wr(ADR_CSR, 32'h1, 4'hF);
        wb_wr(ADR_CSR, 32'h8, 4'hF);
        check("abort_run", 32'(cntrl_run), 0);
        check("abort_busy", 32'(busy), 0);
        cycles(10);
        check("abort_pulses", 32'(pulses), 32'(p0 + 1));
        wb_rd(ADR_CSR, rd);   check("abort_csr", rd, 32'h0);
        wb_rd(ADR_COUNT, rd); check("abort_count", rd, 32'd2);

        // START while busy is ignored
        p0 = pulses;
        wb_wr(ADR_CSR, 32'h1, 4'hF);
        cycles(8);
        wb_rd(ADR_CSR, rd); check("wclr_csr", rd, 32'h120);
        wb_wr(ADR_CSR, 32'h1, 4'hF);
        cycles(8);
        check("restart_pulses", 32'(pulses), 32'(p0 + 1));
        wb_rd(ADR_CSR, rd); check("restart_csr", rd, 32'h120);
        man_ready = 1'b0;
        cycles(5);
        man_ready = 1'b1;
        wait_idle(10, n);
        wb_rd(ADR_COUNT, rd);  check("count3", rd, 32'd3);
        wb_rd(ADR_STATUS, rd); check("status3", rd, 32'h5);
        wb_wr(ADR_STATUS, 32'h1, 4'hF);

`ifdef CAPCTRL_TIMEOUT_EN
        wb_wr(ADR_TIMEOUT, 32'd100, 4'hF);
        wb_rd(ADR_TIMEOUT, rd); check("tmo_reg", rd, 32'd100);
        wb_wr(ADR_CSR, 32'h5, 4'hF);
        wait_idle(200, n);
        check("tmo_cycles", 32'(n >= 103 && n <= 107), 1);
        wb_rd(ADR_STATUS, rd); check("tmo_status", rd, 32'h6);
        check("tmo_irq", 32'(irq), 1);
        wb_rd(ADR_CSR, rd);   check("tmo_csr", rd, 32'h4);
        wb_rd(ADR_COUNT, rd); check("tmo_count", rd, 32'd3);
        wb_wr(ADR_STATUS, 32'h2, 4'hF);
        check("tmo_irq_clr", 32'(irq), 0);
        wb_wr(ADR_TIMEOUT, 32'd0, 4'hF);
`else
        wb_wr(ADR_TIMEOUT, 32'hFFFF_FFFF, 4'hF);
        wb_rd(ADR_TIMEOUT, rd); check("tmo_reg_off", rd, 32'd0);
        wb_wr(ADR_CSR, 32'h5, 4'hF);
        cycles(150);
        check("no_tmo_busy", 32'(busy), 1);
        wb_rd(ADR_STATUS, rd); check("no_tmo_status", rd, 32'h4);
        wb_wr(ADR_CSR, 32'h8, 4'hF);
        check("no_tmo_abort", 32'(busy), 0);
`endif
        exp_count = 3;

        // Randomized captures and register traffic
        ram_en = 1'b1;
        for (int it = 0; it < 16; it++) begin
            exp_irq_en = 1'($urandom_range(0, 1));
            p0 = pulses;
            wb_wr(ADR_CSR, 32'h1 | (32'(exp_irq_en) << 2), 4'hF);
            wait_idle(100, n);
            exp_done = 1'b1;
            if (exp_count < 16'hFFFF) exp_count++;
            check("rnd_pulses", 32'(pulses), 32'(p0 + 1));
            check("rnd_len", 32'(last_len), 32'(RUN_LEN));
            check("rnd_irq", 32'(irq), 32'(exp_irq_en));
            wb_rd(ADR_STATUS, rd); check("rnd_status", rd, 32'h5);
            wb_rd(ADR_COUNT, rd);  check("rnd_count", rd, 32'(exp_count));
            wb_rd(ADR_CSR, rd);    check("rnd_csr", rd, 32'(exp_irq_en) << 2);
            wd = 32'($urandom_range(0, 3));
            wb_wr(ADR_STATUS, wd, 4'hF);
            if (wd[0]) exp_done = 1'b0;
            check("rnd_irq_w1c", 32'(irq), 32'(exp_irq_en & exp_done));
            wb_rd(ADR_STATUS, rd); check("rnd_status_w1c", rd, 32'h4 | 32'(exp_done));
            if ($urandom_range(0, 3) == 0) begin
                wb_wr(ADR_COUNT, $urandom, 4'($urandom_range(0, 15)));
                exp_count = 0;
                wb_rd(ADR_COUNT, rd); check("rnd_count_clr", rd, 0);
            end
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            wb_wr(ADR_TIMEOUT, wd, ws);
`ifdef CAPCTRL_TIMEOUT_EN
            for (int b = 0; b < 3; b++)
                if (ws[b]) exp_lim[b*8 +: 8] = wd[b*8 +: 8];
            wb_rd(ADR_TIMEOUT, rd); check("rnd_timeout", rd, 32'(exp_lim));
            wb_wr(ADR_TIMEOUT, 32'd0, 4'hF);
            exp_lim = '0;
`else
            wb_rd(ADR_TIMEOUT, rd); check("rnd_timeout", rd, 32'(exp_lim));
`endif
        end

        // Reset mid-capture, then a normal capture
        wb_wr(ADR_CSR, 32'h1, 4'hF);
        cycles(2);
        wb_rst = 1'b1;
        cycles(2);
        wb_rst = 1'b0;
        check("rst_mid_run", 32'(cntrl_run), 0);
        check("rst_mid_busy", 32'(busy), 0);
        wb_rd(ADR_COUNT, rd); check("rst_mid_count", rd, 0);
        cycles(40);
        p0 = pulses;
        wb_wr(ADR_CSR, 32'h1, 4'hF);
        wait_idle(100, n);
        check("post_rst_pulses", 32'(pulses), 32'(p0 + 1));
        wb_rd(ADR_COUNT, rd); check("post_rst_count", rd, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
